rr_token_arbiter: RTL

- Round-robin arbiter that shares a single downstream resource (e.g. a circular shifter datapath) among N requesters.
- Rotating priority pointer, one-hot registered grant, and bounded hold time: a contended holder is pre-empted after MAX_HOLD cycles.
- Sits between requesting masters and the shared resource. gnt drives the resource's input select/enable.

---
 rtl/rr_token_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rr_token_arbiter.sv
// -----------------------------------------------------------------------------
// rr_token_arbiter
//
// Round-robin arbiter granting one shared downstream resource to one of N
// requesters. A rotating priority pointer gives fairness. A bounded hold time
// pre-empts a holder that keeps the grant for MAX_HOLD cycles while somebody
// else is waiting.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous reset, active-high
//   req[N]     : level request per requester, held while using the resource
//   gnt[N]     : registered one-hot grant (drives resource select/enable)
//   gnt_valid  : |gnt
//   gnt_id     : index of the granted requester, 0 when nothing is granted
//   timeout    : one-cycle pulse on the first cycle of a forcibly rotated grant
// -----------------------------------------------------------------------------
module rr_token_arbiter #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           timeout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);

    logic [0:0]     state_q,    state_d;
    logic [IDW-1:0] ptr_q,      ptr_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N-1:0]   gnt_q,      gnt_d;
    logic [IDW-1:0] gnt_id_q,   gnt_id_d;
    logic           timeout_q,  timeout_d;

    // Candidates for the search: while a grant is active the current holder
    // is excluded, so the same search serves release and forced rotation.
    logic [N-1:0]   cand;
    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] win_next;
    logic           holder_req;

    assign cand       = (state_q == ST_GRANT) ? (req & ~gnt_q) : req;
    assign holder_req = |(req & gnt_q);
    assign win_next   = (win == LAST_IDX) ? '0 : win + 1'b1;

    // Circular scan starting at ptr_q, ascending and wrapping N-1 -> 0.
    // The index is computed one bit wider so ptr + offset never overflows
    // before the modulo-N fold.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            logic [IDW:0] idx;
            idx = {1'b0, ptr_q} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N)) begin
                idx = idx - (IDW+1)'(N);
            end
            if (!found && cand[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d       = ST_GRANT;
                    gnt_d         = '0;
                    gnt_d[win]    = 1'b1;
                    gnt_id_d      = win;
                    ptr_d         = win_next;
                    hold_cnt_d    = '0;
                end
            end
            default: begin
                if (!holder_req) begin
                    // Release: hand over without an idle gap if possible.
                    hold_cnt_d = '0;
                    if (found) begin
                        gnt_d      = '0;
                        gnt_d[win] = 1'b1;
                        gnt_id_d   = win;
                        ptr_d      = win_next;
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (found) begin
                        // Forced rotation away from a holder that hit the limit.
                        gnt_d      = '0;
                        gnt_d[win] = 1'b1;
                        gnt_id_d   = win;
                        ptr_d      = win_next;
                        timeout_d  = 1'b1;
                    end
                    // Uncontended: holder keeps the grant, counter wraps.
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

endmodule
